cpu_seq_controller: RTL and testbench

- Second-generation multi-cycle CPU control FSM.
- Sequences fetch, decode, operand read and execute for A/I/J instruction classes.
- Adds memory wait-state handshake, absolute and register-indirect operand modes, parametrised register-file enables, illegal-opcode trap and HALT/resume.
- Sits between the instruction register/memory interface and the datapath (PC, internal value register, ALU muxes, register file).

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/cpu_op_decode.sv | 55 +++++
 rtl/cpu_seq_controller.sv | 169 ++++++++++++++++
 tb/tb_cpu_seq_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: FSM states, memory
// address sources, ALU operand sources and instruction classes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        RIMM   = 4'd2,
        RADDR  = 4'd3,
        RVAL   = 4'd4,
        RIND_A = 4'd5,
        RIND_B = 4'd6,
        EXEC   = 4'd7,
        HALT   = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_A   = 2'd0,
        CLS_I   = 2'd1,
        CLS_J   = 2'd2,
        CLS_ILL = 2'd3
    } class_e;

    typedef enum logic [2:0] {
        MODE_REG   = 3'd0,
        MODE_IMM   = 3'd1,
        MODE_ABS   = 3'd2,
        MODE_IND_A = 3'd3,
        MODE_IND_B = 3'd4
    } mode_e;

    localparam logic [1:0] READ_FROM_PC  = 2'd0;
    localparam logic [1:0] READ_FROM_VAL = 2'd1;
    localparam logic [1:0] READ_FROM_A   = 2'd2;
    localparam logic [1:0] READ_FROM_B   = 2'd3;

    localparam logic [2:0] ALU1_PC  = 3'd4;
    localparam logic [2:0] ALU1_MEM = 3'd5;
    localparam logic [2:0] ALU2_ONE = 3'd4;
    localparam logic [2:0] ALU2_OP  = 3'd5;

    localparam logic [3:0] ALU_FUNC_ADD = 4'b0000;
    localparam logic [3:0] ALU_FUNC_JMP = 4'b0110;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational instruction field decoder: class, operand mode, destination
// register and the EXEC-cycle ALU controls.
module cpu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] opcode,
    output class_e      op_class,
    output mode_e       mode,
    output logic [2:0]  dest,
    output logic [3:0]  alu_func,
    output logic [2:0]  alu_a,
    output logic [2:0]  alu_b
);

    logic [2:0] s1;
    assign s1 = opcode[11:9];

    always_comb begin
        if (opcode[15])                 op_class = CLS_J;
        else if (opcode[14])            op_class = CLS_I;
        else if (opcode[13:12] == 2'b00) op_class = CLS_A;
        else                            op_class = CLS_ILL;

        mode = MODE_REG;
        if (s1[2]) begin
            case (s1[1:0])
                2'b00:   mode = MODE_IMM;
                2'b01:   mode = MODE_ABS;
                2'b10:   mode = MODE_IND_A;
                default: mode = MODE_IND_B;
            endcase
        end

        alu_a    = s1[2] ? ALU1_MEM : {1'b0, s1[1:0]};
        alu_b    = {1'b0, opcode[4:3]};
        alu_func = opcode[8:5];
        dest     = {1'b0, opcode[1:0]};

        case (op_class)
            CLS_I: begin
                alu_b    = ALU2_OP;
                alu_func = {opcode[8], opcode[8], opcode[13:12]};
                dest     = s1[2] ? opcode[2:0] : s1;
            end
            CLS_J: begin
                alu_a    = ALU1_PC;
                alu_b    = ALU2_OP;
                alu_func = ALU_FUNC_JMP;
                dest     = 3'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq_controller.sv
// Multi-cycle CPU control FSM: fetch, decode, operand read and execute with
// memory wait states, illegal-opcode trap and HALT/resume.
module cpu_seq_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG         = 3,
    parameter int MEM_WAIT     = 1,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     opcode,
    input  logic            memReady,
    input  logic            resume,
    output logic            memRead,
    output logic [1:0]      memAddr,
    output logic            enPC,
    output logic            saveOpcode,
    output logic            saveMem,
    output logic [3:0]      aluFunc,
    output logic [2:0]      aluA,
    output logic [2:0]      aluB,
    output logic [NREG-1:0] regEn,
    output logic            halted,
    output logic            illegal
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    class_e     op_class;
    mode_e      mode;
    logic [2:0] dest;
    logic [3:0] dec_func;
    logic [2:0] dec_a, dec_b;
    logic       mem_rdy;
    logic       save_op_raw, save_mem_raw, en_pc_raw, reg_wr;

    assign mem_rdy = (MEM_WAIT != 0) ? memReady : 1'b1;

    cpu_op_decode u_dec (
        .opcode   (opcode),
        .op_class (op_class),
        .mode     (mode),
        .dest     (dest),
        .alu_func (dec_func),
        .alu_a    (dec_a),
        .alu_b    (dec_b)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:  if (mem_rdy) state_d = DECODE;
            DECODE: begin
                case (op_class)
                    CLS_ILL: begin
                        if (TRAP_ILLEGAL != 0) begin
                            state_d   = HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                    CLS_J:   state_d = EXEC;
                    default: begin
                        case (mode)
                            MODE_IMM:   state_d = RIMM;
                            MODE_ABS:   state_d = RADDR;
                            MODE_IND_A: state_d = RIND_A;
                            MODE_IND_B: state_d = RIND_B;
                            default:    state_d = EXEC;
                        endcase
                    end
                endcase
            end
            RIMM:   if (mem_rdy) state_d = EXEC;
            RADDR:  if (mem_rdy) state_d = RVAL;
            RVAL, RIND_A, RIND_B: if (mem_rdy) state_d = EXEC;
            EXEC:   state_d = FETCH;
            HALT: begin
                if (resume) begin
                    state_d   = FETCH;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        memRead      = 1'b0;
        memAddr      = READ_FROM_PC;
        aluFunc      = 4'd0;
        aluA         = 3'd0;
        aluB         = 3'd0;
        save_op_raw  = 1'b0;
        save_mem_raw = 1'b0;
        en_pc_raw    = 1'b0;
        reg_wr       = 1'b0;
        halted       = 1'b0;
        case (state_q)
            FETCH: begin
                memRead     = 1'b1;
                aluA        = ALU1_PC;
                aluB        = ALU2_ONE;
                aluFunc     = ALU_FUNC_ADD;
                save_op_raw = mem_rdy;
                en_pc_raw   = mem_rdy;
            end
            RIMM, RADDR: begin
                memRead      = 1'b1;
                aluA         = ALU1_PC;
                aluB         = ALU2_ONE;
                aluFunc      = ALU_FUNC_ADD;
                save_mem_raw = mem_rdy;
                en_pc_raw    = mem_rdy;
            end
            RVAL: begin
                memRead      = 1'b1;
                memAddr      = READ_FROM_VAL;
                save_mem_raw = mem_rdy;
            end
            RIND_A: begin
                memRead      = 1'b1;
                memAddr      = READ_FROM_A;
                save_mem_raw = mem_rdy;
            end
            RIND_B: begin
                memRead      = 1'b1;
                memAddr      = READ_FROM_B;
                save_mem_raw = mem_rdy;
            end
            EXEC: begin
                aluA      = dec_a;
                aluB      = dec_b;
                aluFunc   = dec_func;
                en_pc_raw = (op_class == CLS_J);
                reg_wr    = (op_class == CLS_A) || (op_class == CLS_I);
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Enables are suppressed while reset is asserted so an in-flight stall cannot commit.
    always_comb begin
        regEn = '0;
        for (int i = 0; i < NREG; i++) begin
            regEn[i] = rst && reg_wr && (dest == 3'(i));
        end
    end

    assign saveOpcode = rst && save_op_raw;
    assign saveMem    = rst && save_mem_raw;
    assign enPC       = rst && en_pc_raw;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_seq_controller.sv
// Directed bench for cpu_seq_controller: walks each instruction form cycle by
// cycle and compares outputs against hand-computed values.
module tb_cpu_seq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] opcode;
    logic        memReady;
    logic        resume;

    logic        memRead, enPC, saveOpcode, saveMem, halted, illegal;
    logic [1:0]  memAddr;
    logic [3:0]  aluFunc;
    logic [2:0]  aluA, aluB;
    logic [2:0]  regEn;

    logic        memRead_2, enPC_2, saveOpcode_2, saveMem_2, halted_2, illegal_2;
    logic [1:0]  memAddr_2;
    logic [3:0]  aluFunc_2;
    logic [2:0]  aluA_2, aluB_2;
    logic [1:0]  regEn_2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_seq_controller #(.NREG(3), .MEM_WAIT(1), .TRAP_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady), .resume(resume),
        .memRead(memRead), .memAddr(memAddr), .enPC(enPC), .saveOpcode(saveOpcode),
        .saveMem(saveMem), .aluFunc(aluFunc), .aluA(aluA), .aluB(aluB),
        .regEn(regEn), .halted(halted), .illegal(illegal)
    );

    cpu_seq_controller #(.NREG(2), .MEM_WAIT(1), .TRAP_ILLEGAL(1)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady), .resume(resume),
        .memRead(memRead_2), .memAddr(memAddr_2), .enPC(enPC_2), .saveOpcode(saveOpcode_2),
        .saveMem(saveMem_2), .aluFunc(aluFunc_2), .aluA(aluA_2), .aluB(aluB_2),
        .regEn(regEn_2), .halted(halted_2), .illegal(illegal_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; opcode = 16'h0000; memReady = 1'b0; resume = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_memRead", 32'(memRead), 1);
        check("rst_memAddr", 32'(memAddr), 0);
        check("rst_enables", 32'({saveOpcode, saveMem, enPC, regEn}), 0);
        check("rst_aluFunc", 32'(aluFunc), 0);
        check("rst_halted_illegal", 32'({halted, illegal}), 0);

        // Register A-type, no stalls
        opcode = 16'h0000; memReady = 1'b1;
        #1;
        check("a0_fetch_save", 32'({saveOpcode, enPC}), 3);
        check("a0_fetch_alu", 32'({aluA, aluB, aluFunc}), 32'({3'd4, 3'd4, 4'd0}));
        tick();
        check("a0_decode_quiet", 32'({memRead, saveOpcode, saveMem, enPC, regEn}), 0);
        tick();
        check("a0_exec_regEn", 32'(regEn), 32'b001);
        check("a0_exec_alu", 32'({aluA, aluB, aluFunc}), 0);
        tick();

        // Immediate A-type with two wait cycles in RIMM
        opcode = 16'h0802;
        #1;
        check("imm_fetch_save", 32'(saveOpcode), 1);
        tick();
        memReady = 1'b0;
        tick();
        check("imm_rimm1", 32'({memRead, memAddr, saveMem, enPC}), 32'b10000);
        tick();
        check("imm_rimm2", 32'({memRead, memAddr, saveMem, enPC}), 32'b10000);
        tick();
        memReady = 1'b1;
        #1;
        check("imm_rimm3", 32'({memRead, memAddr, saveMem, enPC}), 32'b10011);
        tick();
        check("imm_exec_aluA", 32'(aluA), 5);
        check("imm_exec_regEn", 32'(regEn), 32'b100);
        tick();

        // Absolute A-type
        opcode = 16'h0A01;
        #1;
        check("abs_fetch_addr", 32'(memAddr), 0);
        tick(); tick();
        check("abs_raddr", 32'({memAddr, saveMem, enPC}), 32'b0011);
        tick();
        check("abs_rval", 32'({memAddr, saveMem, enPC}), 32'b0110);
        tick();
        check("abs_exec_regEn", 32'(regEn), 32'b010);
        tick();

        // Jump
        opcode = 16'h8123;
        tick(); tick();
        check("j_exec_alu", 32'({aluA, aluB, aluFunc}), 32'({3'd4, 3'd5, 4'b0110}));
        check("j_exec_en", 32'({enPC, regEn}), 32'b1000);
        tick();

        // I-type register operand
        opcode = 16'h6210;
        tick(); tick();
        check("i_exec_alu", 32'({aluA, aluB, aluFunc}), 32'({3'd1, 3'd5, 4'b0010}));
        check("i_exec_regEn", 32'(regEn), 32'b010);
        tick();

        // Indirect via A, destination beyond NREG
        opcode = 16'h0C03;
        tick(); tick();
        check("ind_rind_a", 32'({memRead, memAddr, saveMem, enPC}), 32'b11010);
        tick();
        check("ind_exec_regEn", 32'(regEn), 0);
        check("ind_exec_aluA", 32'(aluA), 5);
        tick();

        // NREG=2 instance with destination 2
        opcode = 16'h0002;
        tick(); tick();
        check("nreg2_exec_regEn", 32'(regEn_2), 0);
        check("nreg3_exec_regEn", 32'(regEn), 32'b100);
        tick();

        // Illegal opcode trap and resume
        opcode = 16'h1000;
        tick();
        check("ill_decode_halted", 32'(halted), 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("ill_halt_state", 32'({halted, illegal}), 3);
            check("ill_halt_enables", 32'({saveOpcode, saveMem, enPC, regEn, memRead}), 0);
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        memReady = 1'b0;
        #1;
        check("ill_resume_state", 32'({halted, illegal, memRead}), 1);

        // Reset during a stalled RADDR
        opcode = 16'h0A01; memReady = 1'b1;
        tick();
        memReady = 1'b0;
        tick();
        check("rstmid_raddr_stall", 32'({memRead, saveMem, enPC}), 32'b100);
        tick();
        rst = 1'b0; memReady = 1'b1;
        #1;
        check("rstmid_no_pulse", 32'({saveMem, enPC, saveOpcode}), 0);
        tick();
        rst = 1'b1; memReady = 1'b0;
        #1;
        check("rstmid_fetch", 32'({memRead, memAddr, saveMem, halted}), 32'b10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
